// File: rtl/noc_pkg.sv
// noc_pkg: shared Spidergon router constants, arbiter state and flit type encodings
package noc_pkg;
   localparam int PORT_LOCAL  = 0;
   localparam int PORT_CW     = 1;
   localparam int PORT_CCW    = 2;
   localparam int PORT_ACROSS = 3;
   typedef enum logic {IDLE, LOCKED} arb_state_t;
   typedef enum logic [1:0] {HEAD, BODY, TAIL, HEAD_TAIL} flit_type_t;
endpackage

// File: rtl/spidergon_output_arbiter_if.sv
// spidergon_output_arbiter_if: requester/credit inputs and grant/status outputs of one output-port arbiter
//   master: input ports and downstream credit side (drives flit_*, credit_return)
//   slave : the arbiter (drives grant, out_valid, out_vc, locked, credit_count, protocol_error)
interface spidergon_output_arbiter_if #(
   parameter int NUM_OF_INPUT_PORTS      = 4,
   parameter int NUM_OF_VIRTUAL_CHANNELS = 2,
   parameter int VC_BUFFER_DEPTH         = 2
);
   localparam int N  = NUM_OF_INPUT_PORTS * NUM_OF_VIRTUAL_CHANNELS;
   localparam int CW = $clog2(VC_BUFFER_DEPTH + 1);
   localparam int VW = (NUM_OF_VIRTUAL_CHANNELS > 1) ? $clog2(NUM_OF_VIRTUAL_CHANNELS) : 1;
   logic [N-1:0]                         flit_valid;
   logic [N-1:0]                         flit_is_head;
   logic [N-1:0]                         flit_is_tail;
   logic [NUM_OF_VIRTUAL_CHANNELS-1:0]   credit_return;
   logic [N-1:0]                         grant;
   logic                                 out_valid;
   logic [VW-1:0]                        out_vc;
   logic                                 locked;
   logic [NUM_OF_VIRTUAL_CHANNELS*CW-1:0] credit_count;
   logic                                 protocol_error;
   modport master (
      output flit_valid, flit_is_head, flit_is_tail, credit_return,
      input  grant, out_valid, out_vc, locked, credit_count, protocol_error
   );
   modport slave (
      input  flit_valid, flit_is_head, flit_is_tail, credit_return,
      output grant, out_valid, out_vc, locked, credit_count, protocol_error
   );
endinterface

// File: rtl/spidergon_output_arbiter_rr_priority_select.sv
// rr_priority_select: combinational round-robin picker
//   req: request vector, ptr: highest-priority index, gnt: one-hot winner (zero when no request)
module rr_priority_select #(
   parameter int N  = 8,
   parameter int PW = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]  req,
   input  logic [PW-1:0] ptr,
   output logic [N-1:0]  gnt
);
   // scan from the far end back to ptr so the closest request at/after ptr is written last
   always_comb begin
      gnt = '0;
      for (int i = N - 1; i >= 0; i--)
         if (req[(int'(ptr) + i) % N]) begin
            gnt = '0;
            gnt[(int'(ptr) + i) % N] = 1'b1;
         end
   end
endmodule

// File: rtl/spidergon_output_arbiter.sv
// spidergon_output_arbiter: wormhole switch allocator with per-VC credit counters for one output link
//   clk, reset (async, active-high)
//   bus (slave): flit_valid/flit_is_head/flit_is_tail per requester, credit_return per VC in;
//                grant, out_valid, out_vc, locked, credit_count, protocol_error out
module spidergon_output_arbiter
   import noc_pkg::*;
#(
   parameter int NUM_OF_INPUT_PORTS      = 4,
   parameter int NUM_OF_VIRTUAL_CHANNELS = 2,
   parameter int VC_BUFFER_DEPTH         = 2
) (
   input logic clk,
   input logic reset,
   spidergon_output_arbiter_if.slave bus
);
   localparam int N   = NUM_OF_INPUT_PORTS * NUM_OF_VIRTUAL_CHANNELS;
   localparam int NVC = NUM_OF_VIRTUAL_CHANNELS;
   localparam int CW  = $clog2(VC_BUFFER_DEPTH + 1);
   localparam int PW  = (N > 1) ? $clog2(N) : 1;
   localparam int VW  = (NVC > 1) ? $clog2(NVC) : 1;
   arb_state_t    state;
   logic [PW-1:0] rr_ptr, owner, gidx, next_ptr;
   logic [CW-1:0] credit [NVC];
   logic [CW-1:0] credit_nxt [NVC];
   logic [NVC-1:0] sat_err;
   logic [N-1:0]  eligible, rr_gnt, grant;
   logic          err, stray_body;
   always_comb begin
      eligible = '0;
      for (int i = 0; i < N; i++)
         eligible[i] = bus.flit_valid[i] & (credit[i % NVC] != '0);
   end
   rr_priority_select #(.N(N), .PW(PW)) u_rr (
      .req (eligible & bus.flit_is_head),
      .ptr (rr_ptr),
      .gnt (rr_gnt)
   );
   assign grant = reset ? '0 :
                  (state == IDLE) ? rr_gnt :
                  (eligible[owner] ? (N'(1) << owner) : '0);
   always_comb begin
      gidx = '0;
      for (int i = 0; i < N; i++)
         if (grant[i]) gidx = PW'(i);
   end
   assign next_ptr       = PW'((int'(gidx) + 1) % N);
   assign stray_body     = (state == IDLE) & |(bus.flit_valid & ~bus.flit_is_head);
   assign bus.grant      = grant;
   assign bus.out_valid  = |grant;
   assign bus.out_vc     = bus.out_valid ? VW'(int'(gidx) % NVC) : '0;
   assign bus.locked     = (state == LOCKED);
   assign bus.protocol_error = err;
   // same-cycle decrement and return cancel; a return into a full counter saturates and flags an error
   always_comb begin
      for (int v = 0; v < NVC; v++) begin
         sat_err[v]    = bus.credit_return[v] & ~(bus.out_valid & bus.out_vc == VW'(v)) & (credit[v] == CW'(VC_BUFFER_DEPTH));
         credit_nxt[v] = (bus.credit_return[v] & ~(bus.out_valid & bus.out_vc == VW'(v)) & ~sat_err[v]) ? credit[v] + 1'b1 :
                         (~bus.credit_return[v] & bus.out_valid & bus.out_vc == VW'(v)) ? credit[v] - 1'b1 : credit[v];
      end
   end
   genvar v;
   for (v = 0; v < NVC; v++) begin : g_cc
      assign bus.credit_count[v*CW +: CW] = credit[v];
   end
   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         state  <= IDLE;
         rr_ptr <= '0;
         owner  <= '0;
         credit <= '{default: CW'(VC_BUFFER_DEPTH)};
         err    <= 1'b0;
      end else begin
         credit <= credit_nxt;
         if (bus.out_valid) begin
            if (bus.flit_is_tail[gidx]) begin
               state  <= IDLE;
               rr_ptr <= next_ptr;
            end else if (state == IDLE) begin
               state <= LOCKED;
               owner <= gidx;
            end
         end
         if (stray_body | (|sat_err) | (bus.locked & bus.out_valid & bus.flit_is_head[gidx]))
            err <= 1'b1;
      end
endmodule

// File: tb/tb_spidergon_output_arbiter.sv
// tb_spidergon_output_arbiter: randomized self-checking bench against a packet-level reference model
module tb_spidergon_output_arbiter;
   localparam int P = 4, NVC = 2, D = 2, N = 8, CW = 2;
   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;
   spidergon_output_arbiter_if #(.NUM_OF_INPUT_PORTS(P), .NUM_OF_VIRTUAL_CHANNELS(NVC), .VC_BUFFER_DEPTH(D)) bus();
   spidergon_output_arbiter #(.NUM_OF_INPUT_PORTS(P), .NUM_OF_VIRTUAL_CHANNELS(NVC), .VC_BUFFER_DEPTH(D)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );
   int total = 0, bad = 0;
   int rr, own, g;
   int cr [NVC];
   bit err;
   int len [N];
   int pos [N];
   task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask
   task automatic drive(logic [N-1:0] v, logic [N-1:0] h, logic [N-1:0] t, logic [NVC-1:0] r);
      bus.flit_valid    = v;
      bus.flit_is_head  = h;
      bus.flit_is_tail  = t;
      bus.credit_return = r;
   endtask
   task automatic model_reset();
      rr  = 0;
      own = -1;
      err = 0;
      for (int v = 0; v < NVC; v++) cr[v] = D;
   endtask
   function automatic logic [NVC*CW-1:0] pack_cr();
      logic [NVC*CW-1:0] p;
      for (int v = 0; v < NVC; v++) p[v*CW +: CW] = CW'(cr[v]);
      return p;
   endfunction
   // called just after a negedge with inputs driven; checks, then advances the model over one posedge
   task automatic step(string tag);
      logic [N-1:0] fv, fh, ft, eg;
      logic [NVC-1:0] rt;
      bit nerr;
      #1;
      fv = bus.flit_valid; fh = bus.flit_is_head; ft = bus.flit_is_tail; rt = bus.credit_return;
      g = -1;
      if (own < 0) begin
         for (int j = 0; j < N; j++)
            if (g < 0 && fv[(rr + j) % N] && fh[(rr + j) % N] && cr[((rr + j) % N) % NVC] > 0) g = (rr + j) % N;
      end else if (fv[own] && cr[own % NVC] > 0) g = own;
      eg = (g >= 0) ? (N'(1) << g) : '0;
      check({tag, "_grant"}, 32'(bus.grant), 32'(eg));
      check({tag, "_valid"}, 32'(bus.out_valid), (g >= 0) ? 1 : 0);
      check({tag, "_vc"}, 32'(bus.out_vc), (g >= 0) ? g % NVC : 0);
      check({tag, "_locked"}, 32'(bus.locked), (own >= 0) ? 1 : 0);
      check({tag, "_credit"}, 32'(bus.credit_count), 32'(pack_cr()));
      check({tag, "_err"}, 32'(bus.protocol_error), 32'(err));
      @(posedge clk);
      nerr = err;
      if (own < 0 && |(fv & ~fh)) nerr = 1;
      if (own >= 0 && g >= 0 && fh[g]) nerr = 1;
      for (int v = 0; v < NVC; v++) begin
         bit d;
         d = (g >= 0) && (g % NVC == v);
         if (rt[v] && !d) begin
            if (cr[v] == D) nerr = 1;
            else cr[v]++;
         end else if (d && !rt[v]) cr[v]--;
      end
      if (g >= 0) begin
         if (ft[g]) begin
            own = -1;
            rr  = (g + 1) % N;
         end else if (own < 0) own = g;
      end
      err = nerr;
      @(negedge clk);
   endtask
   task automatic do_reset();
      reset = 1'b1;
      drive('0, '0, '0, '0);
      model_reset();
      #1;
      check("rst_grant", 32'(bus.grant), 0);
      check("rst_locked", 32'(bus.locked), 0);
      check("rst_credit", 32'(bus.credit_count), 32'h0000000a);
      check("rst_err", 32'(bus.protocol_error), 0);
      @(negedge clk);
      reset = 1'b0;
   endtask
   task automatic gen_reset();
      for (int i = 0; i < N; i++) begin
         pos[i] = 0;
         len[i] = $urandom_range(1, 3);
      end
   endtask
   // well-formed packets: only the current owner can be mid-packet, so no stray body flits
   task automatic gen_drive();
      logic [N-1:0] v, h, t;
      logic [NVC-1:0] r;
      for (int i = 0; i < N; i++) begin
         v[i] = ($urandom_range(0, 9) < 7);
         h[i] = (pos[i] == 0);
         t[i] = (pos[i] == len[i] - 1);
      end
      for (int k = 0; k < NVC; k++) r[k] = (cr[k] < D) && ($urandom_range(0, 1) == 1);
      drive(v, h, t, r);
   endtask
   task automatic gen_advance();
      if (g >= 0) begin
         pos[g]++;
         if (pos[g] == len[g]) begin
            pos[g] = 0;
            len[g] = $urandom_range(1, 3);
         end
      end
   endtask
   initial begin
      reset = 1'b1;
      drive('0, '0, '0, '0);
      model_reset();
      @(negedge clk);
      do_reset();
      drive(8'h08, 8'h08, 8'h08, 2'b00);
      #1;
      check("t1_grant", 32'(bus.grant), 32'h08);
      check("t1_vc", 32'(bus.out_vc), 1);
      step("t1");
      drive('0, '0, '0, '0);
      #1;
      check("t1_credit", 32'(bus.credit_count), 32'h6);
      step("t1b");
      drive(8'h90, 8'h80, 8'h80, 2'b00);
      step("t6");
      check("t6_err", 32'(bus.protocol_error), 1);
      do_reset();
      drive('0, '0, '0, 2'b10);
      step("t4");
      check("t4_err", 32'(bus.protocol_error), 1);
      do_reset();
      gen_reset();
      for (int c = 0; c < 800; c++) begin
         gen_drive();
         step("wf");
         gen_advance();
      end
      for (int c = 0; c < 200 && own < 0; c++) begin
         gen_drive();
         step("pre");
         gen_advance();
      end
      check("lock_reached", (own >= 0) ? 1 : 0, 1);
      gen_drive();
      #2;
      reset = 1'b1;
      #1;
      check("arst_grant", 32'(bus.grant), 0);
      check("arst_valid", 32'(bus.out_valid), 0);
      check("arst_locked", 32'(bus.locked), 0);
      check("arst_credit", 32'(bus.credit_count), 32'h0000000a);
      check("arst_err", 32'(bus.protocol_error), 0);
      model_reset();
      @(negedge clk);
      reset = 1'b0;
      drive(8'h22, 8'h22, 8'h00, 2'b00);
      #1;
      check("t5_grant", 32'(bus.grant), 32'h02);
      step("t5");
      for (int c = 0; c < 600; c++) begin
         if (c % 100 == 99) do_reset();
         drive(N'($urandom), N'($urandom), N'($urandom), NVC'($urandom));
         step("rnd");
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/spidergon_output_arbiter.md
Name: spidergon_output_arbiter

Overview:
Per-output-port switch allocator for one Spidergon router node. It shares one output link (local, clockwise, counter-clockwise or across) between all input-port/VC requesters. Allocation is wormhole: a packet holds the link from head flit to tail flit. Credit counters per downstream VC buffer stop the block from overrunning the neighbour. Four instances sit in each node of the NoC, one per output port.

Parameters:
NUM_OF_INPUT_PORTS, 4, input ports competing for this output (local, CW, CCW, across)
NUM_OF_VIRTUAL_CHANNELS, 2, VCs per port; a flit keeps its VC index across the link
VC_BUFFER_DEPTH, 2, flits per downstream VC buffer (NODE_BUFFER_WIDTH/FLIT_DATA_WIDTH); initial credit value
Derived: N = NUM_OF_INPUT_PORTS*NUM_OF_VIRTUAL_CHANNELS; requester i = port*NUM_OF_VIRTUAL_CHANNELS + vc; CW = $clog2(VC_BUFFER_DEPTH+1)

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high reset
flit_valid  in  N  requester i has a flit ready at its VC buffer head
flit_is_head  in  N  that flit is a head flit
flit_is_tail  in  N  that flit is a tail flit (head+tail = single-flit packet)
credit_return  in  NUM_OF_VIRTUAL_CHANNELS  downstream freed one slot of VC v this cycle
grant  out  N  one-hot or zero; requester i's flit crosses the link this cycle
out_valid  out  1  |grant
out_vc  out  $clog2(NUM_OF_VIRTUAL_CHANNELS)  VC of granted flit (i mod NUM_OF_VIRTUAL_CHANNELS); 0 when idle
locked  out  1  a multi-flit packet owns the link
credit_count  out  NUM_OF_VIRTUAL_CHANNELS*CW  packed credit counters, VC0 in LSBs
protocol_error  out  1  sticky error flag

Behaviour:
- Reset (async assert, sync release): state IDLE; rr_ptr=0; owner=0; every credit=VC_BUFFER_DEPTH; protocol_error=0. grant=0, out_valid=0, out_vc=0, locked=0.
- eligible[i] = flit_valid[i] & credit[i mod NVC]>0.
- grant, out_valid and out_vc are combinational from registered state and the current inputs: zero added latency. All state updates on posedge clk.
- IDLE: candidates are eligible[i] & flit_is_head[i]. Grant the first candidate at or after rr_ptr, searching upward with wrap at N.
  - Granted flit is also a tail: stay IDLE; rr_ptr <= winner+1 mod N.
  - Otherwise: go LOCKED; owner <= winner.
  - No candidate: grant=0; nothing changes.
- LOCKED (locked=1): only owner can be granted, and only when eligible[owner]. Other requesters get nothing, even when eligible.
  - Granted flit is a tail: go IDLE; rr_ptr <= owner+1 mod N.
  - Granted flit is a head: set protocol_error; the flit is still forwarded and the state does not change.
- Owner stall (no flit, or zero credit): hold LOCKED with no grant. There is no timeout.
- Non-head flit_valid with no lock in IDLE: no grant; set protocol_error.
- Credits, per VC v:
  - Decrement by 1 when the granted flit uses VC v.
  - Increment by 1 on credit_return[v].
  - Both in the same cycle: value unchanged.
  - credit_return[v] while the counter is already VC_BUFFER_DEPTH: counter saturates and protocol_error is set.
  - A counter at 0 can never underflow because eligibility gates the grant.
- protocol_error clears only on reset.
- Reset mid-packet: state, pointer and credits return to reset values immediately. No grant is issued while reset is high.

Decomposition:
- Shared package noc_pkg holds:
  - port index constants (PORT_LOCAL=0, PORT_CW=1, PORT_CCW=2, PORT_ACROSS=3)
  - the arbiter state enum {IDLE, LOCKED}
  - the flit type field encodings (HEAD, BODY, TAIL, HEAD_TAIL) used by the node buffers
- One sub-module: rr_priority_select, a parameterised combinational round-robin picker. Inputs are a request vector and a pointer; output is a one-hot winner. The node's VC allocator reuses it.

Test Plan:
1. After reset: credit_count = {2,2}, grant=0, locked=0. Requester 3 (port1, VC1) sends a head+tail flit -> grant=8'h08 in the same cycle, out_vc=1; next cycle credit VC1=1, rr_ptr=4, still IDLE.
2. Requesters 0 and 5 hold head flits continuously, each packet 3 flits (head, body, tail), credits returned each cycle -> three grants to 0, then three to 5, then 0 again. locked=1 between head and tail; requester 5 is never granted while 0 owns the link.
3. Credit stall: requester 2 (VC0) sends head, body, body, tail with no credit_return -> grants on cycles 0 and 1 only. Credit VC0 reaches 0, grant=0, locked stays 1. One credit_return[0] pulse -> next flit granted the following cycle.
4. Simultaneous decrement and return on VC1 at credit=1 -> credit stays 1. credit_return[1] while credit VC1=2 -> counter stays 2 and protocol_error=1, held until reset.
5. Reset asserted asynchronously mid-packet, with owner=6 and credits {0,1} -> outputs go to reset values before the next clock edge. After release, a head from requester 1 is granted with rr_ptr=0 ordering.
6. Body flit presented by requester 4 while IDLE -> grant=0 and protocol_error=1. A head flit from requester 7 in the same cycle is still granted.
